// File: rtl/generation_sequencer.sv
// Genetic-algorithm generation scheduler: evaluate, sort, latch ranks, then stream
// (parent A, parent B, child) breeding commands until the generation limit or run drop.
module generation_sequencer #(
  parameter int POP_SIZE = 50,
  parameter int IDX_W    = 6,
  parameter int ELITE    = 8,
  parameter int GEN_MAX  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  output logic                      eval_start,
  input  logic                      eval_done,
  output logic                      sort_start,
  input  logic                      sort_done,
  input  logic [POP_SIZE*IDX_W-1:0] sorted_in,
  output logic                      breed_valid,
  input  logic                      breed_ready,
  output logic [IDX_W-1:0]          parent_a_idx,
  output logic [IDX_W-1:0]          parent_b_idx,
  output logic [IDX_W-1:0]          child_idx,
  output logic [7:0]                gen_count,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    SORT,
    LATCH,
    BREED,
    NEXT,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] ELITE_L = IDX_W'(ELITE);
  localparam logic [IDX_W-1:0] LAST_J  = IDX_W'(POP_SIZE - ELITE - 1);
  localparam logic [7:0]       GEN_LIM = 8'(GEN_MAX);

  function automatic logic [IDX_W-1:0] pick(input logic [POP_SIZE*IDX_W-1:0] v,
                                            input logic [IDX_W-1:0]          r);
    return v[IDX_W*int'(r) +: IDX_W];
  endfunction

  state_t                    state_q, state_d;
  logic [POP_SIZE*IDX_W-1:0] rank_q, rank_d;
  logic [IDX_W-1:0]          a_q, a_d, b_q, b_d, j_q, j_d;
  logic [IDX_W-1:0]          a_nx, b_nx;
  logic [IDX_W-1:0]          pa_d, pb_d, ch_d;
  logic                      eval_start_d, sort_start_d, breed_valid_d;
  logic                      busy_d, done_d;
  logic [7:0]                gen_d, gen_inc;

  // Next ordered elite pair (a != b), a-major, b wrapping inside the elite set.
  always_comb begin
    a_nx = a_q;
    b_nx = b_q + ONE;
    if (b_nx == a_q) begin
      b_nx = b_nx + ONE;
    end
    if (b_nx >= ELITE_L) begin
      a_nx = (a_q == ELITE_L - ONE) ? '0 : a_q + ONE;
      b_nx = (a_nx == '0) ? ONE : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rank_d        = rank_q;
    a_d           = a_q;
    b_d           = b_q;
    j_d           = j_q;
    eval_start_d  = 1'b0;
    sort_start_d  = 1'b0;
    breed_valid_d = breed_valid;
    pa_d          = parent_a_idx;
    pb_d          = parent_b_idx;
    ch_d          = child_idx;
    gen_d         = gen_count;
    gen_inc       = gen_count + 8'd1;

    case (state_q)
      IDLE: begin
        if (run) begin
          gen_d        = '0;
          state_d      = EVAL;
          eval_start_d = 1'b1;
        end
      end
      // The start pulse is high only in the first cycle, so it masks a stale done.
      EVAL: begin
        if (!eval_start && eval_done) begin
          state_d      = SORT;
          sort_start_d = 1'b1;
        end
      end
      SORT: begin
        if (!sort_start && sort_done) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        rank_d        = sorted_in;
        a_d           = '0;
        b_d           = ONE;
        j_d           = '0;
        pa_d          = pick(sorted_in, '0);
        pb_d          = pick(sorted_in, ONE);
        ch_d          = pick(sorted_in, ELITE_L);
        breed_valid_d = 1'b1;
        state_d       = BREED;
      end
      BREED: begin
        if (breed_valid && breed_ready) begin
          if (j_q == LAST_J) begin
            breed_valid_d = 1'b0;
            state_d       = NEXT;
          end else begin
            a_d  = a_nx;
            b_d  = b_nx;
            j_d  = j_q + ONE;
            pa_d = pick(rank_q, a_nx);
            pb_d = pick(rank_q, b_nx);
            ch_d = pick(rank_q, ELITE_L + j_q + ONE);
          end
        end
      end
      NEXT: begin
        gen_d = gen_inc;
        if (gen_inc == GEN_LIM || !run) begin
          state_d = DONE;
        end else begin
          state_d      = EVAL;
          eval_start_d = 1'b1;
        end
      end
      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rank_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      j_q          <= '0;
      eval_start   <= 1'b0;
      sort_start   <= 1'b0;
      breed_valid  <= 1'b0;
      parent_a_idx <= '0;
      parent_b_idx <= '0;
      child_idx    <= '0;
      gen_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      a_q          <= a_d;
      b_q          <= b_d;
      j_q          <= j_d;
      eval_start   <= eval_start_d;
      sort_start   <= sort_start_d;
      breed_valid  <= breed_valid_d;
      parent_a_idx <= pa_d;
      parent_b_idx <= pb_d;
      child_idx    <= ch_d;
      gen_count    <= gen_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_generation_sequencer.sv
// Bench for generation_sequencer: randomized evaluator/sorter/breeder models with a
// command scoreboard fed from an ordered-pair reference list.
module tb_generation_sequencer;

  localparam int POP  = 50;
  localparam int IW   = 6;
  localparam int EL   = 8;
  localparam int GM   = 4;
  localparam int NCMD = POP - EL;

  logic            clk = 1'b0;
  logic            rst_n, run, eval_done, sort_done, breed_ready;
  logic [POP*IW-1:0] sorted_in;
  logic            eval_start, sort_start, breed_valid, busy, done;
  logic [IW-1:0]   parent_a_idx, parent_b_idx, child_idx;
  logic [7:0]      gen_count;

  generation_sequencer #(
    .POP_SIZE(POP), .IDX_W(IW), .ELITE(EL), .GEN_MAX(GM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .eval_start(eval_start), .eval_done(eval_done),
    .sort_start(sort_start), .sort_done(sort_done), .sorted_in(sorted_in),
    .breed_valid(breed_valid), .breed_ready(breed_ready),
    .parent_a_idx(parent_a_idx), .parent_b_idx(parent_b_idx), .child_idx(child_idx),
    .gen_count(gen_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
  } cmd_t;

  cmd_t exp_q[$];
  int   pair_a[$];
  int   pair_b[$];
  int   nvec = 0;
  int   nfail = 0;
  int   xfers = 0;
  int   eval_seen = 0;
  int   rmode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_eval_start"}, eval_start, 0);
    chk({tag, "_sort_start"}, sort_start, 0);
    chk({tag, "_breed_valid"}, breed_valid, 0);
    chk({tag, "_idx"}, {parent_a_idx, parent_b_idx, child_idx}, 0);
    chk({tag, "_gen_count"}, gen_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Breeder: ready changes just after the rising edge, stable for the next sample.
  initial begin
    breed_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       breed_ready = 1'b1;
        1:       breed_ready = ~breed_ready;
        default: breed_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    logic        stall;
    logic        expect_drop;
    logic [31:0] held;
    cmd_t        e;
    stall = 1'b0;
    expect_drop = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        expect_drop = 1'b0;
      end else begin
        if (eval_start) eval_seen++;
        if (expect_drop) begin
          chk("valid_drop_after_last", breed_valid, 0);
          expect_drop = 1'b0;
        end
        if (stall) begin
          chk("stall_hold", {13'd0, breed_valid, parent_a_idx, parent_b_idx, child_idx}, held);
        end
        stall = 1'b0;
        if (breed_valid) begin
          if (breed_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_cmd", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("parent_a", parent_a_idx, e.a);
              chk("parent_b", parent_b_idx, e.b);
              chk("child", child_idx, e.c);
              if (exp_q.size() == 0) expect_drop = 1'b1;
            end
            xfers++;
          end else begin
            stall = 1'b1;
            held = {13'd0, breed_valid, parent_a_idx, parent_b_idx, child_idx};
          end
        end
      end
    end
  end

  // One generation, entered on the negedge where eval_start is seen high.
  // ek/sk: cycles after the start pulse before done is raised (0 = during the pulse).
  task automatic do_gen(input int ek, input int sk, input int rm, input bit fixed,
                        input bit drop, input int abort_n, input int exp_gen,
                        input bit last);
    int   n;
    int   base;
    int   rk[POP];
    cmd_t c;
    rmode = rm;
    base = xfers;
    if (drop) run = 1'b0;

    n = 0;
    eval_done = (ek == 0);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("eval_start_width", eval_start, 0);
      if (n == ek) eval_done = 1'b1;
    end while (!sort_start && n < 40);
    chk("eval_done_to_sort_start", n, (ek + 1 > 2) ? ek + 1 : 2);
    eval_done = 1'b0;

    for (int r = 0; r < POP; r++) begin
      rk[r] = fixed ? POP - 1 - r : int'($urandom_range(0, (1 << IW) - 1));
      sorted_in[IW*r +: IW] = IW'(rk[r]);
    end
    for (int j = 0; j < NCMD; j++) begin
      c.a = rk[pair_a[j % pair_a.size()]];
      c.b = rk[pair_b[j % pair_b.size()]];
      c.c = rk[EL + j];
      exp_q.push_back(c);
    end

    n = 0;
    sort_done = (sk == 0);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("sort_start_width", sort_start, 0);
      if (n == sk) sort_done = 1'b1;
    end while (!breed_valid && n < 40);
    chk("sort_done_to_breed_valid", n, ((sk + 1 > 2) ? sk + 1 : 2) + 1);
    sort_done = 1'b0;
    for (int r = 0; r < POP; r++) sorted_in[IW*r +: IW] = IW'($urandom_range(0, (1 << IW) - 1));

    if (abort_n >= 0) begin
      n = 0;
      while (xfers - base < abort_n && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_point_reached", (xfers - base >= abort_n), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      run = 1'b0;
      exp_q.delete();
      return;
    end

    n = 1;
    forever begin
      @(negedge clk);
      if (!breed_valid || n > 2000) break;
      n++;
    end
    if (rm == 0) chk("no_bubble_len", n, NCMD);
    chk("all_cmds_sent", exp_q.size(), 0);
    chk("transfer_count", xfers - base, NCMD);
    chk("gen_count_before_next", gen_count, exp_gen - 1);
    @(negedge clk);
    chk("gen_count", gen_count, exp_gen);
    chk("done", done, last);
    chk("busy", busy, !last);
    chk("eval_restart", eval_start, !last);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen0;
    for (int a = 0; a < EL; a++)
      for (int b = 0; b < EL; b++)
        if (a != b) begin
          pair_a.push_back(a);
          pair_b.push_back(b);
        end
    rst_n = 1'b0;
    run = 1'b0;
    eval_done = 1'b0;
    sort_done = 1'b0;
    sorted_in = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_no_eval_start", eval_start, 0);
    end

    // Full generation, then reset in the middle of the next BREED.
    run = 1'b1;
    @(negedge clk);
    chk("eval_start_rise", eval_start, 1);
    chk("busy_on_run", busy, 1);
    do_gen(2, 3, 2, 0, 0, -1, 1, 0);
    do_gen(1, 1, 2, 0, 0, 10, 2, 0);
    @(negedge clk);
    check_zero("reset_mid_breed");
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, eval_start}, 0);
    end

    // Single generation with the descending rank vector and breeder always ready.
    run = 1'b1;
    @(negedge clk);
    chk("eval_start_rise", eval_start, 1);
    do_gen(1, 2, 0, 1, 1, -1, 1, 1);
    @(negedge clk);
    chk("done_to_idle", {busy, done}, 0);
    chk("gen_count_hold", gen_count, 1);

    // Early done + toggled ready, random ready, then run dropped in generation 3.
    run = 1'b1;
    @(negedge clk);
    chk("eval_start_rise", eval_start, 1);
    chk("gen_count_cleared", gen_count, 0);
    do_gen(0, 0, 1, 0, 0, -1, 1, 0);
    do_gen(3, 1, 2, 0, 0, -1, 2, 0);
    do_gen(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 2, 0, 1, -1, 3, 1);
    @(negedge clk);
    chk("run_drop_idle", done, 0);
    chk("run_drop_gen_count", gen_count, 3);

    // Generation limit with run held.
    run = 1'b1;
    seen0 = eval_seen;
    @(negedge clk);
    chk("eval_start_rise", eval_start, 1);
    for (int g = 1; g <= GM; g++) begin
      do_gen(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), (g == 1) ? 0 : 2,
             0, 0, -1, g, (g == GM));
    end
    repeat (5) begin
      @(negedge clk);
      chk("done_held_with_run", {done, eval_start}, 2'b10);
    end
    chk("eval_pulses_at_limit", eval_seen - seen0, GM);
    run = 1'b0;
    @(negedge clk);
    chk("limit_to_idle", done, 0);
    chk("limit_gen_count_hold", gen_count, GM);
    run = 1'b1;
    @(negedge clk);
    chk("restart_eval_start", eval_start, 1);
    chk("restart_gen_clear", gen_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
